p_fxp_acc_pipe: RTL and testbench
=================================

# p_fxp_acc_pipe

Pipelined, multi-beat fixed-point accumulator. Each beat reduces an `IN`-lane vector through a registered adder tree, then sums successive beats into a wide accumulator until a `last` beat. It delivers one `PREC`-bit result per vector, with selectable saturate or wrap output conversion, over valid/ready handshakes. It serves as the streaming reduction stage for perceptron dot-products longer than one input vector, feeding the activation stage.

## Interface
- `IN`, 8: lanes per beat; must be ≥2; non-power-of-two allowed.
- `CONF`, `` `DEF_DCONF_FXP ``: fixed-point format (`dconf_t`: sign, frac, prec); input and output share it.
- `PREC`, `CONF.prec`: data width.
- `SAT`, 1: 1 = saturate on output overflow, 0 = wrap (truncate).
- `GUARD`, 8: extra accumulator integer bits beyond tree growth.
- Ports:
- `clk` in 1: clock, rising edge.
- `reset_` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: block accepts a beat this cycle.
- `in_last` in 1: beat is the final beat of a vector.
- `in` in `IN`×`PREC`: lane data.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `out` out `PREC`: vector result.
- `ovf` out 1: overflow flag for the presented result, qualified by `out_valid`.

## Operation
- Formats:
  - `SIGN=1`: two's complement.
  - `SIGN=0`: unsigned.
  - Fractional point is unchanged throughout; no rounding occurs.
- Lane padding: `EIN = 1<<$clog2(IN)`; lanes `IN..EIN-1` are zero.
- Adder tree:
  - `STAGE=$clog2(IN)` levels, one register stage per level.
  - Level k sums are `PREC+k` bits, sign- or zero-extended, so the tree never overflows.
- Accumulator:
  - Width `AW = PREC+STAGE+GUARD`.
  - When a tree result reaches it: `acc = (first ? 0 : acc) + tree`; `first` is then set to the `last` flag that travelled with the beat.
  - Overflow beyond `AW`: clamp to the AW min/max and set a sticky vector overflow bit.
  - The sticky bit clears at the start of each vector.
- Output conversion, on the `last` beat:
  - `SAT=1`: clamp to the `PREC` range; `ovf=1` if clamped or the sticky bit is set.
  - `SAT=0`: low `PREC` bits; `ovf=1` if the discarded bits are not a sign/zero extension of the kept bits, or the sticky bit is set.
- Flow control:
  - Global stall `stall = out_valid & ~out_ready`.
  - `in_ready = ~stall`.
  - During a stall all tree registers, the accumulator and its flags hold.
  - Valid bits propagate with the data; bubbles are allowed and do not disturb `acc`.
- Non-last beats update `acc` only; they never touch `out`/`out_valid`.

## Timing
- Reset values (async, while `reset_`=0):
  - `out_valid`=0, `out`=0, `ovf`=0.
  - All stage valids 0, `acc`=0, `first`=1, sticky bit 0.
  - `in_ready`=1 (follows from `out_valid`=0).
- Latency: a `last` beat accepted at edge t produces `out_valid`=1 after edge t+STAGE+1.
- Throughput: one beat per cycle with no stall; one result per cycle possible (every beat `last`).
- `out` and `ovf` are stable while `out_valid & ~out_ready`.
- `out_valid & out_ready` in the same cycle a new last result arrives: `out` reloads and `out_valid` stays 1, with no bubble.
- Handshake with no new result: `out_valid` falls next edge.
- `in_valid` while `in_ready`=0: beat is not taken; the source must hold it.
- Reset asserted mid-vector: partial sum and in-flight beats are discarded; the next accepted beat starts a new vector.
- `in_last` on every beat: each beat is an independent vector, and the accumulator is not carried over.

## Test plan
Defaults: `PREC`=16, `FRAC`=8, signed, `IN`=8 (latency 4), `SAT`=1.
- Single beat, all lanes 0x0100, last=1 -> `out`=0x0800 four cycles after acceptance, `ovf`=0.
- Three beats, lanes 0x0040, last on the third -> one result 0x0600, `ovf`=0; no `out_valid` for beats 1–2.
- All lanes 0x7FFF, one beat:
  - `SAT=1` -> 0x7FFF, `ovf`=1.
  - `SAT=0` -> 0xFFF8, `ovf`=1.
  - All lanes 0x8000 with `SAT=1` -> 0x8000, `ovf`=1.
- `IN`=5, lanes {0xFF00, 0, 0, 0, 0x0200} -> 0x0100 (padded lanes zero), `ovf`=0.
- Back-to-back single-beat vectors 1..20 (lanes 0x0100 × k) with `out_ready` low for cycles 5–14:
  - `in_ready` drops within the stall.
  - All 20 results arrive in order, none lost or duplicated, each `out` held while stalled.
- Two beats of 0x0100 without last, then `reset_` pulse, then a one-beat vector of 0x0080 -> `out`=0x0400 (old beats excluded).
- Reset values checked during the pulse.

Source files
------------

// File: rtl/p_fxp_acc_pipe.sv
// p_fxp_acc_pipe: pipelined multi-beat fixed-point accumulator. Each beat of IN
// lanes goes through a registered adder tree; successive tree sums are added into
// a wide accumulator until a beat flagged last, which produces one PREC-bit result.
// Latency: a last beat accepted at edge t is presented after edge t+STAGE+1.
// Backpressure: a held result (out_valid & ~out_ready) freezes the whole pipe and
// drops in_ready; beats are only taken while the output is free to advance.
//
// Ports:
//   clk, reset_          clock (rising edge) and asynchronous active-low reset
//   in_valid/in_ready    beat handshake; in_last marks the final beat of a vector
//   in                   IN lanes of PREC bits in the CONF fixed-point format
//   out_valid/out_ready  result handshake
//   out                  PREC-bit result (saturated or wrapped per SAT)
//   ovf                  overflow flag for the presented result

package p_fxp_acc_pipe_pkg;
  // Fixed-point format descriptor shared by input and output.
  typedef struct packed {
    logic       sign;  // 1: two's complement, 0: unsigned
    logic [7:0] frac;  // fractional bits (point position is carried through untouched)
    logic [7:0] prec;  // total data width
  } dconf_t;
endpackage

`ifndef DEF_DCONF_FXP
`define DEF_DCONF_FXP '{sign: 1'b1, frac: 8'd8, prec: 8'd16}
`endif

module p_fxp_acc_pipe
  import p_fxp_acc_pipe_pkg::*;
#(
  parameter int     IN    = 8,
  parameter dconf_t CONF  = `DEF_DCONF_FXP,
  parameter int     PREC  = int'(CONF.prec),
  parameter bit     SAT   = 1'b1,
  parameter int     GUARD = 8
) (
  input  logic                    clk,
  input  logic                    reset_,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [IN-1:0][PREC-1:0] in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PREC-1:0]         out,
  output logic                    ovf
);

  localparam int STAGE = $clog2(IN);       // tree levels, one register each
  localparam int EIN   = 1 << STAGE;       // lanes after zero padding
  localparam int NODES = EIN - 1;          // total tree nodes over all levels
  localparam int TW    = PREC + STAGE;     // tree output width, never overflows
  localparam int AW    = TW + GUARD;       // accumulator width
  localparam bit SIGN  = CONF.sign;

  // Tree nodes are stored level after level in one flat array:
  // level k (1..STAGE) holds EIN>>k nodes starting at this index.
  function automatic int lvl_base(input int k);
    return EIN - (EIN >> (k - 1));
  endfunction

  // Sign- or zero-extend a lane to the tree width.
  function automatic logic [TW-1:0] ext_tw(input logic [PREC-1:0] x);
    return {{(TW - PREC){SIGN & x[PREC-1]}}, x};
  endfunction

  // ---------------------------------------------------------------------------
  // Global stall: a presented result that is not taken freezes everything.
  // ---------------------------------------------------------------------------
  logic stall;
  logic out_valid_q;

  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;

  // ---------------------------------------------------------------------------
  // Adder tree
  // ---------------------------------------------------------------------------
  logic [TW-1:0]    lane [EIN];
  logic [TW-1:0]    node_q [NODES];
  logic [TW-1:0]    node_d [NODES];
  logic [STAGE-1:0] vld_q, vld_d;
  logic [STAGE-1:0] last_q, last_d;

  // Lanes beyond IN are padding and contribute zero.
  always_comb begin
    for (int i = 0; i < EIN; i++) begin
      lane[i] = '0;
    end
    for (int i = 0; i < IN; i++) begin
      lane[i] = ext_tw(in[i]);
    end
  end

  // Every level is computed at the full tree width; the bits above PREC+k at
  // level k are pure extension bits, so the arithmetic is identical to a tree
  // that grows one bit per level.
  always_comb begin
    node_d = node_q;
    vld_d  = vld_q;
    last_d = last_q;
    if (!stall) begin
      for (int j = 0; j < EIN / 2; j++) begin
        node_d[j] = lane[2*j] + lane[2*j+1];
      end
      for (int k = 2; k <= STAGE; k++) begin
        for (int j = 0; j < (EIN >> k); j++) begin
          node_d[lvl_base(k) + j] = node_q[lvl_base(k-1) + 2*j]
                                  + node_q[lvl_base(k-1) + 2*j + 1];
        end
      end
      // The beat is accepted exactly when it is valid and we are not stalled,
      // so the first valid bit simply samples in_valid.
      vld_d[0]  = in_valid;
      last_d[0] = in_last;
      for (int k = 1; k < STAGE; k++) begin
        vld_d[k]  = vld_q[k-1];
        last_d[k] = last_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < NODES; i++) begin
        node_q[i] <= '0;
      end
      vld_q  <= '0;
      last_q <= '0;
    end else begin
      node_q <= node_d;
      vld_q  <= vld_d;
      last_q <= last_d;
    end
  end

  logic [TW-1:0] tree_sum;
  logic          tree_vld;
  logic          tree_last;

  assign tree_sum  = node_q[NODES-1];
  assign tree_vld  = vld_q[STAGE-1];
  assign tree_last = last_q[STAGE-1];

  // ---------------------------------------------------------------------------
  // Accumulator
  // ---------------------------------------------------------------------------
  logic [AW-1:0] acc_q, acc_d;
  logic          first_q, first_d;    // next tree sum starts a new vector
  logic          sticky_q, sticky_d;  // accumulator clamped during this vector
  logic          done_q, done_d;      // acc_q holds a finished vector

  logic [AW:0]   base_x, tree_x, sum_x;
  logic [AW-1:0] acc_clamp;
  logic [AW-1:0] acc_sum;
  logic          acc_ovf;
  logic          sticky_sum;

  // One extra bit of headroom catches overflow: for two's complement the top
  // two bits of the sum disagree, for unsigned the carry out is set.
  always_comb begin
    base_x = first_q ? '0 : {SIGN & acc_q[AW-1], acc_q};
    tree_x = {{(AW + 1 - TW){SIGN & tree_sum[TW-1]}}, tree_sum};
    sum_x  = base_x + tree_x;
    if (SIGN) begin
      acc_ovf   = sum_x[AW] ^ sum_x[AW-1];
      acc_clamp = sum_x[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end else begin
      acc_ovf   = sum_x[AW];
      acc_clamp = '1;
    end
    acc_sum    = acc_ovf ? acc_clamp : sum_x[AW-1:0];
    sticky_sum = (~first_q & sticky_q) | acc_ovf;
  end

  // Bubbles (tree_vld low) leave the accumulator untouched.
  always_comb begin
    acc_d    = acc_q;
    first_d  = first_q;
    sticky_d = sticky_q;
    done_d   = done_q;
    if (!stall) begin
      done_d = tree_vld & tree_last;
      if (tree_vld) begin
        acc_d    = acc_sum;
        first_d  = tree_last;
        sticky_d = sticky_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      acc_q    <= '0;
      first_q  <= 1'b1;
      sticky_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      first_q  <= first_d;
      sticky_q <= sticky_d;
      done_q   <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output conversion and result register
  // ---------------------------------------------------------------------------
  logic [AW-PREC:0]   hi_s;   // bits that must all equal the sign bit
  logic [AW-PREC-1:0] hi_u;   // bits that must all be zero
  logic [PREC-1:0]    sat_val;
  logic [PREC-1:0]    conv_val;
  logic               oor;

  // Out-of-range is the same test for both modes: saturation clamps on it,
  // wrapping keeps the low bits and only flags it.
  always_comb begin
    hi_s = acc_q[AW-1:PREC-1];
    hi_u = acc_q[AW-1:PREC];
    if (SIGN) begin
      oor     = ~((&hi_s) | ~(|hi_s));
      sat_val = acc_q[AW-1] ? {1'b1, {(PREC-1){1'b0}}} : {1'b0, {(PREC-1){1'b1}}};
    end else begin
      oor     = |hi_u;
      sat_val = '1;
    end
    conv_val = (SAT && oor) ? sat_val : acc_q[PREC-1:0];
  end

  logic            out_valid_d;
  logic [PREC-1:0] out_q, out_d;
  logic            ovf_q, ovf_d;

  // When not stalled the register either reloads with a new result (so a
  // handshake and a new result in the same cycle leave no bubble) or drops
  // valid. Data is left as is when valid drops.
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    ovf_d       = ovf_q;
    if (!stall) begin
      out_valid_d = done_q;
      if (done_q) begin
        out_d = conv_val;
        ovf_d = oor | sticky_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_p_fxp_acc_pipe.sv
// Bench for p_fxp_acc_pipe: three instances run in lockstep on the same stimulus
// (IN=8 saturating, IN=8 wrapping, IN=5 saturating fed lanes 0..4). A reference
// model computes the expected results per accepted beat into a scoreboard queue.

module tb_p_fxp_acc_pipe;

  typedef logic [7:0][15:0] lanes_t;

  typedef struct {
    logic [15:0] o_sat;
    logic        ovf_sat;
    logic [15:0] o_wrap;
    logic        ovf_wrap;
    logic [15:0] o5;
    logic        ovf5;
  } exp_t;

  localparam longint AMAX = (64'sd1 <<< 26) - 1;  // 27-bit accumulator range
  localparam longint AMIN = -(64'sd1 <<< 26);

  logic        clk;
  logic        reset_;
  logic        in_valid;
  logic        in_last;
  lanes_t      in_dat;
  logic        out_ready;

  logic        rdy_m, rdy_w, rdy_5;
  logic        vld_m, vld_w, vld_5;
  logic [15:0] out_m, out_w, out_5;
  logic        ovf_m, ovf_w, ovf_5;

  p_fxp_acc_pipe #(.IN(8), .SAT(1'b1)) u_dut (
    .clk(clk), .reset_(reset_), .in_valid(in_valid), .in_ready(rdy_m),
    .in_last(in_last), .in(in_dat), .out_valid(vld_m), .out_ready(out_ready),
    .out(out_m), .ovf(ovf_m));

  p_fxp_acc_pipe #(.IN(8), .SAT(1'b0)) u_dut_wrap (
    .clk(clk), .reset_(reset_), .in_valid(in_valid), .in_ready(rdy_w),
    .in_last(in_last), .in(in_dat), .out_valid(vld_w), .out_ready(out_ready),
    .out(out_w), .ovf(ovf_w));

  p_fxp_acc_pipe #(.IN(5), .SAT(1'b1)) u_dut_in5 (
    .clk(clk), .reset_(reset_), .in_valid(in_valid), .in_ready(rdy_5),
    .in_last(in_last), .in(in_dat[4:0]), .out_valid(vld_5), .out_ready(out_ready),
    .out(out_5), .ovf(ovf_5));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;
  int n_out  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  exp_t   sb[$];
  longint m_acc8, m_acc5;
  bit     m_st8, m_st5;
  bit     m_first = 1'b1;

  task automatic acc_step(inout longint acc, inout bit st, input bit first, input longint s);
    longint v;
    bit     o;
    v = (first ? 64'sd0 : acc) + s;
    o = 1'b0;
    if (v > AMAX) begin v = AMAX; o = 1'b1; end
    else if (v < AMIN) begin v = AMIN; o = 1'b1; end
    st  = (first ? 1'b0 : st) | o;
    acc = v;
  endtask

  function automatic logic [16:0] conv(input longint v, input bit st, input bit sat);
    bit          oor;
    logic [15:0] o;
    oor = (v > 32767) || (v < -32768);
    if (sat && oor) o = (v > 0) ? 16'h7FFF : 16'h8000;
    else            o = v[15:0];
    return {oor | st, o};
  endfunction

  task automatic model_beat(input lanes_t d, input bit last);
    longint      s8, s5;
    logic [16:0] r;
    exp_t        e;
    s8 = 0;
    s5 = 0;
    for (int i = 0; i < 8; i++) begin
      s8 += longint'($signed(d[i]));
      if (i < 5) s5 += longint'($signed(d[i]));
    end
    acc_step(m_acc8, m_st8, m_first, s8);
    acc_step(m_acc5, m_st5, m_first, s5);
    m_first = last;
    if (last) begin
      r = conv(m_acc8, m_st8, 1'b1); e.o_sat  = r[15:0]; e.ovf_sat  = r[16];
      r = conv(m_acc8, m_st8, 1'b0); e.o_wrap = r[15:0]; e.ovf_wrap = r[16];
      r = conv(m_acc5, m_st5, 1'b1); e.o5     = r[15:0]; e.ovf5     = r[16];
      sb.push_back(e);
    end
  endtask

  task automatic model_reset();
    m_acc8  = 0;
    m_acc5  = 0;
    m_st8   = 1'b0;
    m_st5   = 1'b0;
    m_first = 1'b1;
  endtask

  function automatic lanes_t splat(input logic [15:0] v);
    lanes_t l;
    for (int i = 0; i < 8; i++) l[i] = v;
    return l;
  endfunction

  // ---------------------------------------------------------------- driver
  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_beat(input lanes_t d, input bit last);
    bit taken;
    int n;
    taken    = 1'b0;
    n        = 0;
    in_valid = 1'b1;
    in_last  = last;
    in_dat   = d;
    while (!taken && n < 300) begin
      #1;
      taken = rdy_m;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    if (taken) model_beat(d, last);
    else       check_eq("beat_accept_timeout", taken, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, sb.size(), 0);
  endtask

  // ---------------------------------------------------------------- monitor
  bit          prev_stall = 1'b0;
  logic [15:0] prev_out;
  logic        prev_ovf;
  exp_t        mon_e;

  always @(negedge clk) begin
    #3;
    if (!reset_) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_vld", vld_m, 1'b1);
        check_eq("hold_out", out_m, prev_out);
        check_eq("hold_ovf", ovf_m, prev_ovf);
      end
      if (vld_m && out_ready) begin
        check_eq("sb_nonempty", sb.size() != 0, 1'b1);
        check_eq("wrap_vld", vld_w, 1'b1);
        check_eq("in5_vld", vld_5, 1'b1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check_eq("out_sat", out_m, mon_e.o_sat);
          check_eq("ovf_sat", ovf_m, mon_e.ovf_sat);
          check_eq("out_wrap", out_w, mon_e.o_wrap);
          check_eq("ovf_wrap", ovf_w, mon_e.ovf_wrap);
          check_eq("out_in5", out_5, mon_e.o5);
          check_eq("ovf_in5", ovf_5, mon_e.ovf5);
          n_out++;
        end
      end
      prev_stall = vld_m && !out_ready;
      prev_out   = out_m;
      prev_ovf   = ovf_m;
    end
  end

  bit rand_ready = 1'b0;
  always @(negedge clk) begin
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic check_reset_vals();
    check_eq("rst_out_valid", vld_m, 1'b0);
    check_eq("rst_out", out_m, 16'h0000);
    check_eq("rst_ovf", ovf_m, 1'b0);
    check_eq("rst_in_ready", rdy_m, 1'b1);
    check_eq("rst_in_ready_wrap", rdy_w, 1'b1);
    check_eq("rst_in_ready_in5", rdy_5, 1'b1);
  endtask

  // ---------------------------------------------------------------- tests
  initial begin
    lanes_t v;
    bit     saw_stall;
    int     n_base;

    reset_    = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_dat    = '0;
    out_ready = 1'b1;
    model_reset();
    @(negedge clk);
    #3 check_reset_vals();
    @(negedge clk);
    reset_ = 1'b1;
    @(negedge clk);

    // Single beat, exact latency: valid after edge t+4.
    send_beat(splat(16'h0100), 1'b1);
    repeat (3) @(negedge clk);
    #3 check_eq("lat_not_yet", vld_m, 1'b0);
    @(negedge clk);
    #3 check_eq("lat_valid", vld_m, 1'b1);
    drain("drain_single");
    @(negedge clk);

    // Three beats, one result.
    send_beat(splat(16'h0040), 1'b0);
    send_beat(splat(16'h0040), 1'b0);
    send_beat(splat(16'h0040), 1'b1);
    drain("drain_three");

    // Positive and negative full scale, padded-lane vector.
    send_beat(splat(16'h7FFF), 1'b1);
    send_beat(splat(16'h8000), 1'b1);
    v = '0;
    v[0] = 16'hFF00;
    v[4] = 16'h0200;
    send_beat(v, 1'b1);
    drain("drain_edges");

    // Back-to-back vectors 1..20 with out_ready low for 10 cycles.
    saw_stall = 1'b0;
    n_base    = n_out;
    fork
      begin
        for (int k = 1; k <= 20; k++) send_beat(splat(16'(k * 256)), 1'b1);
      end
      begin
        repeat (5) @(negedge clk);
        out_ready = 1'b0;
        repeat (10) begin
          #1 if (!rdy_m) saw_stall = 1'b1;
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    drain("drain_stall");
    check_eq("in_ready_dropped", saw_stall, 1'b1);
    check_eq("stall_result_count", n_out - n_base, 20);

    // Random multi-beat vectors with random backpressure.
    rand_ready = 1'b1;
    for (int vec = 0; vec < 8; vec++) begin
      int nb;
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        for (int i = 0; i < 8; i++) v[i] = 16'($urandom_range(0, 4095)) - 16'h0800;
        send_beat(v, b == nb - 1);
      end
    end
    @(negedge clk);
    rand_ready = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    drain("drain_random");

    // Reset mid-vector discards the partial sum.
    send_beat(splat(16'h0100), 1'b0);
    send_beat(splat(16'h0100), 1'b0);
    reset_ = 1'b0;
    #3 check_reset_vals();
    @(negedge clk);
    reset_ = 1'b1;
    model_reset();
    @(negedge clk);
    n_base = n_out;
    send_beat(splat(16'h0080), 1'b1);
    drain("drain_after_reset");
    check_eq("post_reset_count", n_out - n_base, 1);

    repeat (3) @(negedge clk);
    check_eq("no_extra_valid", vld_m, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
